// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// carrying a single borrow flop between bits. Result and borrow-out land with a done pulse.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             B
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sa, sb, r;
    logic [WIDTH-1:0] sa_next, sb_next, r_next, d_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             br, br_next, b_next, busy_next, done_next;
    logic             a0, b0, dbit, br_bit;
    logic [WIDTH-1:0] r_shift;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa   <= '0;
            sb   <= '0;
            r    <= '0;
            cnt  <= '0;
            br   <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            D    <= '0;
            B    <= 1'b0;
        end else begin
            sa   <= sa_next;
            sb   <= sb_next;
            r    <= r_next;
            cnt  <= cnt_next;
            br   <= br_next;
            busy <= busy_next;
            done <= done_next;
            D    <= d_next;
            B    <= b_next;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        sa_next    = sa;
        sb_next    = sb;
        r_next     = r;
        cnt_next   = cnt;
        br_next    = br;
        busy_next  = busy;
        done_next  = 1'b0;
        d_next     = D;
        b_next     = B;

        // Full-subtractor cell on the current LSBs.
        a0     = sa[0];
        b0     = sb[0];
        dbit   = a0 ^ b0 ^ br;
        br_bit = (~a0 & b0) | (~(a0 ^ b0) & br);

        // Shift the new difference bit into the MSB; written this way it also covers WIDTH=1.
        r_shift            = r >> 1;
        r_shift[WIDTH-1]   = dbit;

        unique case (state)
            IDLE: begin
                if (start) begin
                    sa_next    = a;
                    sb_next    = b;
                    br_next    = 1'b0;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                sa_next  = sa >> 1;
                sb_next  = sb >> 1;
                r_next   = r_shift;
                br_next  = br_bit;
                cnt_next = cnt + CW'(1);
                if (cnt == LAST) begin
                    d_next     = r_shift;
                    b_next     = br_bit;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
Bit-serial unsigned subtractor. It computes a − b one bit per clock, LSB first, and keeps a single borrow flip-flop between bits (half-subtractor/full-subtractor cell).
- It is the subtraction counterpart to the team's adder cells, for use where area matters more than latency.
- Operands are captured on a start handshake.
- The result and borrow-out are presented with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 1.

Ports:
clk    input   1      clock, rising-edge
rst    input   1      reset, asynchronous, active-high
start  input   1      request; sampled only when idle
a      input   WIDTH  minuend, unsigned; captured on accepted start
b      input   WIDTH  subtrahend, unsigned; captured on accepted start
busy   output  1      high while an operation is in progress
done   output  1      one-cycle pulse when D/B are updated
D      output  WIDTH  difference, (a − b) mod 2^WIDTH
B      output  1      borrow-out; 1 iff a < b (unsigned)

Behaviour:
Interface:
- One clock, clk.
- rst is asynchronous and active-high.
- All other state changes occur on the rising edge of clk.

Reset (asynchronous, any time including mid-operation):
- busy=0, done=0, D=0, B=0.
- FSM goes to IDLE; shift registers, borrow flop and bit counter are cleared.
- An in-flight operation is abandoned and no done pulse is produced.

FSM states: IDLE, RUN.
- IDLE: on an edge with start=1:
  - load internal shift registers sa<=a, sb<=b;
  - borrow flop br<=0, counter cnt<=0;
  - go to RUN; busy<=1.
- IDLE with start=0: remain in IDLE; all outputs hold.
- RUN: each edge processes bit cnt, using a0=sa[0], b0=sb[0]:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - shift d into the MSB of the internal result register r, shifting r right;
  - shift sa and sb right by 1; cnt <= cnt+1.
- RUN, last bit (cnt == WIDTH−1) on that edge:
  - D <= final r (including this bit), B <= br_next;
  - done <= 1, busy <= 0, go to IDLE.

Latency:
- start sampled at edge k → done high in the cycle after edge k+WIDTH.
- Initiation interval is WIDTH+1 cycles.

done:
- High for exactly one cycle, then done <= 0 on the next edge.

D/B:
- Change only at completion (or reset).
- Hold the previous result throughout RUN and IDLE.

start handling:
- start while busy=1 is ignored; operands are not recaptured.
- start=1 in the cycle where done=1 (FSM is in IDLE) is accepted; back-to-back operation is legal.
- a and b are don't-care except at the accepting edge.

Widths:
- cnt is $clog2(WIDTH)+1 bits wide.
- WIDTH=1: RUN lasts one edge; D=a^b, B=~a&b.

No arithmetic overflow other than the borrow; B is the only indication of a negative result.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, start for 1 cycle → busy high for 8 cycles; done pulse 9 edges after start; D=0x1E, B=0.
- a=0x00, b=0x01 → D=0xFF, B=1. a=0x80, b=0x80 → D=0x00, B=0. a=0xFF, b=0x00 → D=0xFF, B=0.
- Start 0x10−0x01, then pulse start with a=0x77, b=0x11 at cycle 3 of RUN → result still D=0x0F, B=0; second request is not executed.
- Assert rst asynchronously mid-RUN (cycle 4) → busy, done, D, B are 0 immediately; no done pulse follows.
- Hold start=1 continuously with a=0x03, b=0x05 → done pulses every 9 cycles; each pulse shows D=0xFE, B=1.
- Rebuild with WIDTH=1, exhaustive a,b ∈ {0,1} → (D,B) = (0,0), (1,1), (1,0), (0,0); done arrives 2 edges after start.
